// File: rtl/program_mem_controller.sv
// program_mem_controller: round-robin arbiter of fetcher reads onto program-memory channels
module program_mem_controller #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0] mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    input  logic [NUM_CHANNELS-1:0] mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data
);
    localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    typedef enum logic [1:0] {IDLE, WAITING, RELAYING} state_t;
    state_t state [NUM_CHANNELS];
    logic [IW-1:0] idx [NUM_CHANNELS];
    logic [IW-1:0] gnt_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] gnt;
    logic [NUM_CONSUMERS-1:0] claimed, pend;
    logic [IW-1:0] rr_ptr, rr_next;
    int j;
    always_comb begin
        pend = consumer_read_valid & ~claimed;
        gnt = '0;
        rr_next = rr_ptr;
        j = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            gnt_idx[c] = '0;
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                j = (int'(rr_ptr) + k) % NUM_CONSUMERS;
                if (state[c] == IDLE && !gnt[c] && pend[j]) begin
                    gnt[c] = 1'b1;
                    gnt_idx[c] = IW'(j);
                end
            end
            if (gnt[c]) begin
                pend[gnt_idx[c]] = 1'b0;
                rr_next = IW'((int'(gnt_idx[c]) + 1) % NUM_CONSUMERS);
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                idx[c] <= '0;
            end
            claimed <= '0;
            rr_ptr <= '0;
            mem_read_valid <= '0;
            mem_read_address <= '0;
            consumer_read_ready <= '0;
            consumer_read_data <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (gnt[c]) begin
                        idx[c] <= gnt_idx[c];
                        claimed[gnt_idx[c]] <= 1'b1;
                        mem_read_valid[c] <= 1'b1;
                        mem_read_address[c*ADDR_BITS +: ADDR_BITS] <= consumer_read_address[gnt_idx[c]*ADDR_BITS +: ADDR_BITS];
                        state[c] <= WAITING;
                    end
                    WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c] <= 1'b0;
                        consumer_read_data[idx[c]*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                        consumer_read_ready[idx[c]] <= 1'b1;
                        state[c] <= RELAYING;
                    end
                    default: if (!consumer_read_valid[idx[c]]) begin
                        consumer_read_ready[idx[c]] <= 1'b0;
                        claimed[idx[c]] <= 1'b0;
                        state[c] <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_mem_controller.sv
// tb_program_mem_controller: randomized checks of arbitration order, data relay and reset against a request-level model
module tb_program_mem_controller;
    logic clk, reset;
    logic [3:0] v1, r1, v2, r2;
    logic [31:0] a1, a2;
    logic [63:0] d1, d2;
    logic mv1, mr1;
    logic [7:0] ma1;
    logic [15:0] md1;
    logic [1:0] mv2, mr2;
    logic [15:0] ma2;
    logic [31:0] md2;
    logic [15:0] mem_model [256];
    logic [7:0] req_addr [4];
    int rem [4];
    int tests, fails, issued, done_cnt, model_rr, wcnt, cur_lat, lat_min, lat_max;
    bit prev_mv, noise, rand_start;
    int grants [$];

    program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v1), .consumer_read_address(a1),
        .consumer_read_ready(r1), .consumer_read_data(d1),
        .mem_read_valid(mv1), .mem_read_address(ma1),
        .mem_read_ready(mr1), .mem_read_data(md1));

    program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v2), .consumer_read_address(a2),
        .consumer_read_ready(r2), .consumer_read_data(d2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        v1 = 0; a1 = 0; mr1 = 0; md1 = 0;
        v2 = 0; a2 = 0; mr2 = 0; md2 = 0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        grants.delete();
        issued = 0; done_cnt = 0; model_rr = 0; wcnt = 0;
        prev_mv = 0; noise = 0; rand_start = 0;
        lat_min = 0; lat_max = 0; cur_lat = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    // One cycle of fetcher and memory behaviour for the single-channel instance, with model checks
    task automatic tick1();
        logic [3:0] vs;
        int g, e;
        @(posedge clk); #1;
        vs = v1;
        if (mv1 && !prev_mv) begin
            g = int'(ma1[7:6]);
            e = -1;
            for (int k = 0; k < 4; k++)
                if (e < 0 && vs[(model_rr + k) % 4]) e = (model_rr + k) % 4;
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL grant_order: got consumer %0d, want %0d", g, e);
            end
            tests++;
            if (ma1 !== req_addr[g]) begin
                fails++;
                $display("FAIL grant_addr: got %h, want %h", ma1, req_addr[g]);
            end
            grants.push_back(g);
            model_rr = (g + 1) % 4;
        end
        prev_mv = mv1;
        tests++;
        if ($countones(r1) > 1) begin
            fails++;
            $display("FAIL ready_overlap: got %b, want at most one bit", r1);
        end
        md1 = mem_model[ma1];
        if (mv1) begin
            mr1 = (wcnt >= cur_lat);
            wcnt++;
        end else begin
            wcnt = 0;
            cur_lat = $urandom_range(lat_min, lat_max);
            mr1 = noise ? 1'($urandom) : 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (v1[i] && r1[i]) begin
                tests++;
                if (d1[i*16 +: 16] !== mem_model[req_addr[i]]) begin
                    fails++;
                    $display("FAIL data_c%0d: got %h, want %h", i, d1[i*16 +: 16], mem_model[req_addr[i]]);
                end
                done_cnt++;
                v1[i] = 0;
            end else if (!v1[i] && !r1[i] && rem[i] > 0 && (!rand_start || $urandom_range(0, 2) == 0)) begin
                req_addr[i] = {2'(i), 6'($urandom)};
                a1[i*8 +: 8] = req_addr[i];
                v1[i] = 1;
                rem[i]--;
                issued++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        v1 = 0; a1 = 0; mr1 = 0; md1 = 0;
        v2 = 0; a2 = 0; mr2 = 0; md2 = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({mv1, ma1, r1, d1} !== '0) begin
            fails++;
            $display("FAIL reset_dut1: got %h, want 0", {mv1, ma1, r1, d1});
        end
        tests++;
        if ({mv2, ma2, r2, d2} !== '0) begin
            fails++;
            $display("FAIL reset_dut2: got %h, want 0", {mv2, ma2, r2, d2});
        end
    endtask

    task automatic test_single();
        do_reset();
        v1 = 4'b0001; a1[7:0] = 8'h12; mr1 = 1; md1 = 16'hBEEF;
        @(posedge clk); #1;
        tests++;
        if ({mv1, ma1, r1} !== {1'b1, 8'h12, 4'b0000}) begin
            fails++;
            $display("FAIL single_grant: got mv=%b addr=%h rdy=%b, want mv=1 addr=12 rdy=0000", mv1, ma1, r1);
        end
        @(posedge clk); #1;
        tests++;
        if ({mv1, r1, d1[15:0]} !== {1'b0, 4'b0001, 16'hBEEF}) begin
            fails++;
            $display("FAIL single_done: got mv=%b rdy=%b data=%h, want mv=0 rdy=0001 data=beef", mv1, r1, d1[15:0]);
        end
        v1 = 0;
        @(posedge clk); #1;
        tests++;
        if ({mv1, r1, d1[15:0]} !== {1'b0, 4'b0000, 16'hBEEF}) begin
            fails++;
            $display("FAIL single_release: got mv=%b rdy=%b data=%h, want mv=0 rdy=0000 data=beef", mv1, r1, d1[15:0]);
        end
    endtask

    task automatic test_contention();
        int exp_o [4] = '{0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 1;
        for (int t = 0; t < 60 && done_cnt < 4; t++) tick1();
        tests++;
        if (grants.size() != 4 || done_cnt != 4) begin
            fails++;
            $display("FAIL contention_count: got grants=%0d done=%0d, want 4 and 4", grants.size(), done_cnt);
        end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            tests++;
            if (grants[i] !== exp_o[i]) begin
                fails++;
                $display("FAIL contention_order[%0d]: got %0d, want %0d", i, grants[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_o [4] = '{0, 2, 0, 2};
        do_reset();
        rem[0] = 2; rem[2] = 2;
        for (int t = 0; t < 60 && done_cnt < 4; t++) tick1();
        tests++;
        if (grants.size() != 4) begin
            fails++;
            $display("FAIL fairness_count: got %0d, want 4", grants.size());
        end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            tests++;
            if (grants[i] !== exp_o[i]) begin
                fails++;
                $display("FAIL fairness_order[%0d]: got %0d, want %0d", i, grants[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_latency5();
        do_reset();
        lat_min = 5; lat_max = 5;
        rem[1] = 1;
        tick1();
        for (int k = 0; k < 5; k++) begin
            tick1();
            tests++;
            if ({mv1, ma1, r1} !== {1'b1, req_addr[1], 4'b0000}) begin
                fails++;
                $display("FAIL latency_hold[%0d]: got mv=%b addr=%h rdy=%b, want mv=1 addr=%h rdy=0000", k, mv1, ma1, r1, req_addr[1]);
            end
        end
        for (int t = 0; t < 10 && done_cnt < 1; t++) tick1();
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL latency_done: got %0d completions, want 1", done_cnt);
        end
    endtask

    task automatic test_drop_early();
        int hi;
        do_reset();
        lat_min = 3; lat_max = 3;
        rem[2] = 1;
        tick1();
        tick1();
        v1[2] = 0;
        hi = 0;
        for (int t = 0; t < 12; t++) begin
            tick1();
            if (r1[2]) hi++;
        end
        tests++;
        if (hi != 1 || d1[47:32] !== mem_model[req_addr[2]] || mv1 !== 1'b0) begin
            fails++;
            $display("FAIL drop_early: got ready_cycles=%0d data=%h mv=%b, want 1 %h 0", hi, d1[47:32], mv1, mem_model[req_addr[2]]);
        end
        rem[3] = 1;
        for (int t = 0; t < 12 && done_cnt < 1; t++) tick1();
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL drop_reuse: got %0d completions, want 1", done_cnt);
        end
    endtask

    task automatic test_two_channels();
        do_reset();
        v2 = 4'b1010; a2[15:8] = 8'h47; a2[31:24] = 8'hC9;
        mr2 = 2'b11; md2 = {16'hB0B0, 16'hA0A0};
        @(posedge clk); #1;
        tests++;
        if ({mv2, ma2} !== {2'b11, 8'hC9, 8'h47}) begin
            fails++;
            $display("FAIL two_grant: got mv=%b addr=%h, want mv=11 addr=c947", mv2, ma2);
        end
        @(posedge clk); #1;
        tests++;
        if ({mv2, r2, d2[31:16], d2[63:48]} !== {2'b00, 4'b1010, 16'hA0A0, 16'hB0B0}) begin
            fails++;
            $display("FAIL two_done: got mv=%b rdy=%b d1=%h d3=%h, want 00 1010 a0a0 b0b0", mv2, r2, d2[31:16], d2[63:48]);
        end
        v2 = 0;
        @(posedge clk); #1;
        tests++;
        if (r2 !== 4'b0000) begin
            fails++;
            $display("FAIL two_release: got %b, want 0000", r2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_min = 50; lat_max = 50;
        rem[0] = 1;
        tick1();
        tick1();
        tests++;
        if (mv1 !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: got mv=%b, want 1", mv1);
        end
        reset = 0;
        #1;
        tests++;
        if ({mv1, ma1, r1, d1, mv2, r2} !== '0) begin
            fails++;
            $display("FAIL midreset_async: got mv=%b addr=%h rdy=%b data=%h, want all 0", mv1, ma1, r1, d1);
        end
        #1 reset = 1;
        v1 = 0; mr1 = 1; md1 = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({mv1, r1} !== 5'b0) begin
                fails++;
                $display("FAIL midreset_late[%0d]: got mv=%b rdy=%b, want 0 0000", k, mv1, r1);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 0; lat_max = 3;
        noise = 1; rand_start = 1;
        for (int i = 0; i < 4; i++) rem[i] = 6;
        for (int t = 0; t < 1500 && done_cnt < 24; t++) tick1();
        tests++;
        if (done_cnt != 24 || issued != 24) begin
            fails++;
            $display("FAIL random_done: got done=%0d issued=%0d, want 24 24", done_cnt, issued);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int k = 0; k < 256; k++) mem_model[k] = 16'($urandom);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_latency5();
        test_drop_early();
        test_two_channels();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
